// File: rtl/uart_tx_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_ctrl
//
// Transmit FIFO between the APB register block and the UART TX state machine.
// Storage is a flop array with first-word-fall-through read: the head entry
// is always presented on rd_data, and the TX FSM takes it by asserting
// rd_ready in the same cycle it samples rd_data. One push and one pop can
// complete per clock at any fill level, including when full.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous reset, active low
//   tx_en        TX enable; low blocks pops, pushes are still accepted
//   flush        synchronous clear, overrides push/pop/overflow update
//   wr_en        push request
//   wr_data      push data
//   rd_ready     TX FSM consumes the head entry this cycle
//   clr_ovf      clear sticky overflow (a same-cycle set wins)
//   rd_valid     head present and tx_en high
//   rd_data      head entry, 0 when empty
//   full         count == DEPTH
//   empty        count == 0
//   almost_full  count >= AF_LEVEL
//   count        number of stored entries
//   overflow     sticky: a push was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module uart_tx_fifo_ctrl #(
   parameter  int DATA_W   = 8,
   parameter  int DEPTH    = 32,
   parameter  int AF_LEVEL = DEPTH - 4,
   localparam int CNT_W    = $clog2(DEPTH) + 1,
   localparam int PTR_W    = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              tx_en,
   input  logic              flush,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_ready,
   input  logic              clr_ovf,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic [CNT_W-1:0]  count,
   output logic              overflow
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q,  count_d;
   logic              ovf_q,    ovf_d;

   logic pop_ok;
   logic push_ok;
   logic push_drop;

   // Status flags come straight from the registered count.
   assign empty       = (count_q == '0);
   assign full        = (count_q == CNT_W'(DEPTH));
   assign almost_full = (count_q >= CNT_W'(AF_LEVEL));
   assign count       = count_q;
   assign overflow    = ovf_q;

   assign rd_valid = !empty && tx_en;
   // Stale memory contents are masked so the TX side never sees old data.
   assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];

   assign pop_ok    = rd_valid && rd_ready;
   // When full, a concurrent pop frees the slot the push is about to fill.
   assign push_ok   = wr_en && (!full || pop_ok);
   assign push_drop = wr_en && !push_ok;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
         // Set has priority over clear.
         if (push_drop) begin
            ovf_d = 1'b1;
         end else if (clr_ovf) begin
            ovf_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage: flush blocks the write so a same-cycle push is discarded.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push_ok && !flush) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
module tb_uart_tx_fifo_ctrl;

   localparam int DATA_W   = 8;
   localparam int DEPTH    = 32;
   localparam int AF_LEVEL = DEPTH - 4;
   localparam int CNT_W    = $clog2(DEPTH) + 1;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic              tx_en;
   logic              flush;
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              rd_ready;
   logic              clr_ovf;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic [CNT_W-1:0]  count;
   logic              overflow;

   int n_total = 0;
   int n_pass  = 0;

   // Reference model: an ordered list of stored characters plus the sticky flag.
   logic [DATA_W-1:0] model_q[$];
   bit                ovf_m;

   uart_tx_fifo_ctrl #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .AF_LEVEL(AF_LEVEL)
   ) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .tx_en      (tx_en),
      .flush      (flush),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .rd_ready   (rd_ready),
      .clr_ovf    (clr_ovf),
      .rd_valid   (rd_valid),
      .rd_data    (rd_data),
      .full       (full),
      .empty      (empty),
      .almost_full(almost_full),
      .count      (count),
      .overflow   (overflow)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
   endtask

   task automatic check_outputs(input string tag);
      int n;
      logic [DATA_W-1:0] head;
      n    = model_q.size();
      head = (n > 0) ? model_q[0] : '0;
      check_eq({tag, ".rd_valid"},    32'(rd_valid),    32'((n > 0) && tx_en));
      check_eq({tag, ".rd_data"},     32'(rd_data),     32'(head));
      check_eq({tag, ".count"},       32'(count),       32'(n));
      check_eq({tag, ".full"},        32'(full),        32'(n == DEPTH));
      check_eq({tag, ".empty"},       32'(empty),       32'(n == 0));
      check_eq({tag, ".almost_full"}, 32'(almost_full), 32'(n >= AF_LEVEL));
      check_eq({tag, ".overflow"},    32'(overflow),    32'(ovf_m));
   endtask

   // Apply one cycle of inputs, check outputs mid-cycle, clock, update model.
   task automatic cyc(input string tag, input bit we, input logic [DATA_W-1:0] wd,
                      input bit rr, input bit te, input bit fl, input bit co);
      int  n;
      bit  pop, push;
      wr_en    = we;
      wr_data  = wd;
      rd_ready = rr;
      tx_en    = te;
      flush    = fl;
      clr_ovf  = co;
      #2;
      check_outputs(tag);
      @(posedge clk_i);
      n = model_q.size();
      if (fl) begin
         model_q.delete();
         ovf_m = 1'b0;
      end else begin
         pop  = (n > 0) && te && rr;
         push = we && ((n < DEPTH) || pop);
         if (pop)  void'(model_q.pop_front());
         if (push) model_q.push_back(wd);
         if (we && !push) ovf_m = 1'b1;
         else if (co)     ovf_m = 1'b0;
      end
      #1;
   endtask

   initial begin
      rst_ni   = 1'b0;
      tx_en    = 1'b1;
      flush    = 1'b0;
      wr_en    = 1'b0;
      wr_data  = '0;
      rd_ready = 1'b0;
      clr_ovf  = 1'b0;
      ovf_m    = 1'b0;
      #3;
      check_outputs("reset");
      #10;
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;

      // Fill 0x00..0x1F without popping.
      for (int i = 0; i < DEPTH; i++) cyc("fill", 1, 8'(i), 0, 1, 0, 0);
      check_eq("fill_full",  32'(full),  32'd1);
      check_eq("fill_count", 32'(count), 32'(DEPTH));

      // Overflow: dropped push, then clear.
      cyc("ovf_push", 1, 8'hAA, 0, 1, 0, 0);
      check_eq("ovf_set",   32'(overflow), 32'd1);
      check_eq("ovf_count", 32'(count),    32'(DEPTH));
      cyc("ovf_clr", 0, 8'h00, 0, 1, 0, 1);
      check_eq("ovf_cleared", 32'(overflow), 32'd0);

      // Full with simultaneous push and pop.
      cyc("full_pp", 1, 8'h55, 1, 1, 0, 0);
      check_eq("full_pp_count", 32'(count),    32'(DEPTH));
      check_eq("full_pp_ovf",   32'(overflow), 32'd0);

      // Drain: 0x01..0x1F then 0x55.
      for (int i = 0; i < DEPTH; i++) begin
         check_eq("drain_order", 32'(rd_data), (i < DEPTH - 1) ? 32'(i + 1) : 32'h55);
         cyc("drain", 0, 8'h00, 1, 1, 0, 0);
      end
      check_eq("drain_empty", 32'(empty),   32'd1);
      check_eq("drain_rdata", 32'(rd_data), 32'd0);

      // Wrap-around: three rounds of 20 pushes then 20 pops.
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 20; i++) cyc("wrap_push", 1, 8'(r * 20 + i), 0, 1, 0, 0);
         for (int i = 0; i < 20; i++) begin
            check_eq("wrap_order", 32'(rd_data), 32'(r * 20 + i));
            cyc("wrap_pop", 0, 8'h00, 1, 1, 0, 0);
         end
      end
      check_eq("wrap_count", 32'(count), 32'd0);

      // tx_en gating, then flush with a same-cycle push.
      for (int i = 0; i < 3; i++) cyc("gate_push", 1, 8'hC0 + 8'(i), 1, 0, 0, 0);
      check_eq("gate_valid", 32'(rd_valid), 32'd0);
      check_eq("gate_count", 32'(count),    32'd3);
      cyc("gate_resume", 0, 8'h00, 1, 1, 0, 0);
      cyc("flush", 1, 8'hEE, 0, 1, 1, 0);
      check_eq("flush_count", 32'(count), 32'd0);
      check_eq("flush_empty", 32'(empty), 32'd1);
      cyc("post_flush", 0, 8'h00, 0, 1, 0, 0);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         cyc("rand",
             ($urandom_range(0, 99) < 60),
             8'($urandom),
             ($urandom_range(0, 99) < ((i / 500) % 2 ? 70 : 35)),
             ($urandom_range(0, 99) < 85),
             ($urandom_range(0, 199) == 0),
             ($urandom_range(0, 29) == 0));
      end

      // Asynchronous reset mid-stream with count = 10.
      cyc("pre_rst_flush", 0, 8'h00, 0, 1, 1, 0);
      for (int i = 0; i < 10; i++) cyc("pre_rst", 1, 8'h30 + 8'(i), 0, 1, 0, 0);
      check_eq("pre_rst_count", 32'(count), 32'd10);
      wr_en = 1'b0;
      #2;
      rst_ni = 1'b0;
      #1;
      model_q.delete();
      ovf_m = 1'b0;
      check_outputs("async_rst");
      #2;
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      cyc("post_rst_push", 1, 8'h5A, 0, 1, 0, 0);
      check_eq("post_rst_data",  32'(rd_data),  32'h5A);
      check_eq("post_rst_valid", 32'(rd_valid), 32'd1);
      cyc("post_rst_pop", 0, 8'h00, 1, 1, 0, 0);
      cyc("final", 0, 8'h00, 0, 1, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo_ctrl.md
# uart_tx_fifo_ctrl

Parametrised transmit FIFO between the APB register interface and the UART TX state machine, replacing the fixed 32×8 transmit buffer. It has explicit full/empty tracking, a first-word-fall-through pop handshake toward the TX FSM and a synchronous flush. It also provides an occupancy count, an almost-full threshold and a sticky overflow flag for the APB status register. Storage is a flop array; one write and one read can complete per clock.

## Interface
- DATA_W, 8: character width in bits.
- DEPTH, 32: number of entries; power of two, ≥ 2.
- AF_LEVEL, DEPTH-4: almost-full threshold, in the range 1..DEPTH.
- CNT_W, $clog2(DEPTH)+1: width of the count output (derived; do not override).

Ports:
- clk_i  in  1  system clock; all state changes on the rising edge.
- rst_ni  in  1  asynchronous reset, active low.
- tx_en  in  1  TX enable; when low, pops are blocked and writes are still accepted.
- flush  in  1  synchronous clear of the FIFO contents.
- wr_en  in  1  push request from APB (one per cycle).
- wr_data  in  DATA_W  push data.
- rd_ready  in  1  TX FSM takes the head entry this cycle.
- clr_ovf  in  1  clears the overflow flag.
- rd_valid  out  1  head entry is present and tx_en=1.
- rd_data  out  DATA_W  head entry (fall-through); 0 when empty.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LEVEL.
- count  out  CNT_W  number of stored entries.
- overflow  out  1  sticky: a push was dropped.

## Operation
- Pointers: wr_ptr and rd_ptr, each log2(DEPTH) bits, wrap modulo DEPTH. Full and empty are derived from count, not from pointer comparison.
- Pop accepted (pop_ok) = rd_valid & rd_ready. On pop_ok, rd_ptr increments.
- Push accepted (push_ok) = wr_en & (!full | pop_ok). On push_ok, mem[wr_ptr] ← wr_data and wr_ptr increments.
- Push while full with no pop: data is dropped, pointers are unchanged, and overflow is set.
- Simultaneous push_ok and pop_ok: count is unchanged and both pointers advance. When full, the pushed word lands in the slot that is being freed.
- Push while empty with rd_ready=1: no pop occurs (rd_valid=0) and the push is accepted.
- count next = count + push_ok − pop_ok. It never exceeds DEPTH and never underflows.
- flush has priority over everything, including a same-cycle push or pop:
  - wr_ptr, rd_ptr and count go to 0; overflow is cleared.
  - Memory contents are not required to clear, but rd_data must read 0 while empty.
- overflow: set on a dropped push; cleared by clr_ovf or flush. If a set and clr_ovf occur in the same cycle, set wins.
- rd_valid = !empty & tx_en. rd_data = empty ? 0 : mem[rd_ptr], combinational from the registered storage.
- tx_en low: the FIFO holds its head and accepts writes up to full. Raising tx_en again resumes from the same head.

## Timing
- Reset (asynchronous, rst_ni=0):
  - Pointers and count are 0; memory is all zeros.
  - Outputs: rd_valid=0, rd_data=0, empty=1, full=0, almost_full=0, count=0, overflow=0.
  - Reset asserted mid-operation discards all entries immediately, without waiting for a clock.
- Write-to-read latency: a push at edge N makes rd_valid=1 and rd_data valid after edge N (usable in cycle N+1). There is no extra pipeline stage.
- Pop: the TX FSM samples rd_data in the same cycle it asserts rd_ready. The next entry appears after that edge.
- All status outputs are registered-state derived and update on the edge following the causing event.
- Sustained throughput: one push and one pop per cycle at any fill level, including full.

## Test plan
- Fill and drain, DEPTH=32, tx_en=1, rd_ready=0: push 0x00..0x1F → after 32 pushes full=1, count=32, almost_full asserted from count 28. Then rd_ready=1 pops 0x00..0x1F in order, ending with empty=1 and rd_data=0.
- Overflow: with the FIFO full, push 0xAA without a pop → overflow=1, count stays 32, and 0xAA never appears at rd_data. Then clr_ovf=1 → overflow=0.
- Full with simultaneous push and pop: full with head 0x00, push 0x55 and rd_ready=1 in the same cycle → count stays 32, overflow=0, and 0x55 is read out as the 32nd word after the 31 remaining entries.
- Wrap-around: push 20 / pop 20 three times with incrementing data → data order is preserved across pointer wrap and count returns to 0.
- tx_en gating and flush: with tx_en=0, push 3 words and hold rd_ready=1 → rd_valid=0 and count=3. Then tx_en=1 → head delivered. Then flush together with wr_en=1 → count=0, empty=1, and the pushed word is discarded.
- Asynchronous reset mid-stream: assert rst_ni=0 between clock edges with count=10 → all outputs reach their reset values immediately. After release, the first push appears at rd_data one cycle later.
